// File: rtl/seq_cmp_pkg.sv
// Shared types and sizing helpers for the digit-serial magnitude comparator.
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_cmp_state_e;

  // One-hot comparison result: exactly one bit set while a result is presented.
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } seq_cmp_res_t;

  // Number of DIGIT_W-bit digits in an N-bit operand.
  function automatic int seq_cmp_num_digits(input int n, input int digit_w);
    return n / digit_w;
  endfunction

  // Digit counter width: ceil(log2(D)), never less than one bit.
  function automatic int seq_cmp_cnt_w(input int n, input int digit_w);
    int d;
    d = n / digit_w;
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/seq_cmp_digit.sv
// Combinational compare of one DIGIT_W-bit digit pair (unsigned).
module seq_cmp_digit #(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] a_digit_i,
  input  logic [DIGIT_W-1:0] b_digit_i,
  output logic               d_lt,
  output logic               d_gt
);

  assign d_lt = (a_digit_i < b_digit_i);
  assign d_gt = (a_digit_i > b_digit_i);

endmodule

// File: rtl/seq_comparator.sv
// Digit-serial unsigned magnitude comparator with valid/ready on both sides.
// Operands are scanned MSB-first, DIGIT_W bits per cycle; the first unequal
// digit decides the result through sticky flags.
// Optional feature: define SEQ_CMP_EARLY_EXIT_EN to leave the scan as soon as
// an unequal digit is found (variable latency). Undefined: fixed D+1 latency.
module seq_comparator
  import seq_cmp_pkg::*;
#(
  parameter int N       = 8,
  parameter int DIGIT_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt
);

  localparam int D     = seq_cmp_num_digits(N, DIGIT_W);
  localparam int CNT_W = seq_cmp_cnt_w(N, DIGIT_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(D - 1);

  seq_cmp_state_e   state_q;
  logic [N-1:0]     a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lt_f_q, gt_f_q;
  logic             lt_f_d, gt_f_d;
  logic             out_valid_q;
  seq_cmp_res_t     res_q;
  logic             d_lt, d_gt;
  logic             run_done;

  // Compare the current top digit of both shift registers.
  seq_cmp_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .a_digit_i (a_q[N-1 -: DIGIT_W]),
    .b_digit_i (b_q[N-1 -: DIGIT_W]),
    .d_lt      (d_lt),
    .d_gt      (d_gt)
  );

  // Sticky flag update and RUN exit condition for the current digit.
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    lt_f_d   = lt_f_q | (~(lt_f_q | gt_f_q) & d_lt);
    gt_f_d   = gt_f_q | (~(lt_f_q | gt_f_q) & d_gt);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    run_done = (cnt_q == LAST_CNT) || d_lt || d_gt;
`else
    run_done = (cnt_q == LAST_CNT);
`endif
  end

  // FSM, operand shift registers, digit counter, flags and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are cleared on reset too, so no stale operand survives an abort.
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      lt_f_q      <= 1'b0;
      gt_f_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            lt_f_q  <= 1'b0;
            gt_f_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q    <= a_q << DIGIT_W;
          b_q    <= b_q << DIGIT_W;
          lt_f_q <= lt_f_d;
          gt_f_q <= gt_f_d;
          if (run_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            res_q.lt    <= lt_f_d;
            res_q.gt    <= gt_f_d;
            res_q.eq    <= ~(lt_f_d | gt_f_d);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign lt        = res_q.lt;
  assign eq        = res_q.eq;
  assign gt        = res_q.gt;

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator (N=8, DIGIT_W=2, D=4).
// Result vectors are {lt, eq, gt}; latencies count the accept edge as cycle 0.
module tb_seq_comparator;

  localparam int N = 8;
  localparam int DW = 2;
  localparam int FULL_LAT = 5;
  localparam int MAX_WAIT = 40;
`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [2:0] R_LT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_GT = 3'b001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic         lt, eq, gt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_comparator #(.N(N), .DIGIT_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lt        (lt),
    .eq        (eq),
    .gt        (gt)
  );

  // One complete transaction with out_ready=1; ee_lat is the early-exit latency.
  task automatic run_op(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                        input logic [2:0] exp_res, input int ee_lat);
    int lat;
    int exp_lat;
    exp_lat = EE ? ee_lat : FULL_LAT;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_before: in_ready=%b expected 1", name, in_ready);
    end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv;
    lat = 1;
    while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
      checks++;
      if ({lt, eq, gt} !== 3'b000 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_busy: cycle %0d res=%b in_ready=%b expected 000/0", name, lat, {lt, eq, gt}, in_ready);
      end
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if ({lt, eq, gt} !== exp_res) begin
      failures++;
      $display("FAIL %s_result: got %b expected %b", name, {lt, eq, gt}, exp_res);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {lt, eq, gt} !== 3'b000) begin
      failures++;
      $display("FAIL %s_after: out_valid=%b in_ready=%b res=%b expected 0/1/000", name, out_valid, in_ready, {lt, eq, gt});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {lt, eq, gt} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b res=%b expected 1/0/000", in_ready, out_valid, {lt, eq, gt});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_compare();
    run_op("equal_5a",     8'h5A, 8'h5A, R_EQ, 5);
    run_op("msb_c0_40",    8'hC0, 8'h40, R_GT, 2);
    run_op("lsb_01_02",    8'h01, 8'h02, R_LT, 5);
    run_op("msb_80_7f",    8'h80, 8'h7F, R_GT, 2);
    run_op("zero_vs_ff",   8'h00, 8'hFF, R_LT, 2);
    run_op("equal_ff",     8'hFF, 8'hFF, R_EQ, 5);
    run_op("lsb_37_36",    8'h37, 8'h36, R_GT, 5);
    run_op("digit1_10_20", 8'h10, 8'h20, R_LT, 3);
    run_op("digit2_a4_a8", 8'hA4, 8'hA8, R_LT, 4);
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    a = 8'hC0; b = 8'h40; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_timeout: out_valid=%b expected 1 within %0d cycles", out_valid, MAX_WAIT);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = 8'h00; b = 8'hFF;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {lt, eq, gt} !== R_GT) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b res=%b expected 1/0/001", i, out_valid, in_ready, {lt, eq, gt});
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {lt, eq, gt} !== 3'b000) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b res=%b expected 1/0/000", in_ready, out_valid, {lt, eq, gt});
    end
  endtask

  task automatic test_reset_in_run();
    a = 8'h01; b = 8'h02; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {lt, eq, gt} !== 3'b000) begin
      failures++;
      $display("FAIL rst_run_immediate: in_ready=%b out_valid=%b res=%b expected 1/0/000", in_ready, out_valid, {lt, eq, gt});
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || {lt, eq, gt} !== 3'b000) begin
        failures++;
        $display("FAIL rst_run_no_result: cycle %0d out_valid=%b res=%b expected 0/000", i, out_valid, {lt, eq, gt});
      end
    end
    run_op("post_reset_10_20", 8'h10, 8'h20, R_LT, 3);
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    a = 8'h80; b = 8'h7F; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h3C; b = 8'h3C;
    lat = 1;
    while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== (EE ? 2 : FULL_LAT) || {lt, eq, gt} !== R_GT) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d res=%b expected %0d/001", lat, {lt, eq, gt}, (EE ? 2 : FULL_LAT));
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: in_ready=%b expected 0", in_ready);
    end
    in_valid = 1'b0; a = 8'hFF; b = 8'h00;
    lat = 1;
    while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== FULL_LAT || {lt, eq, gt} !== R_EQ) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d res=%b expected %0d/010", lat, {lt, eq, gt}, FULL_LAT);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_backpressure();
    test_reset_in_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
